// File: rtl/fifo_pkg.sv
// Shared capture-FIFO definitions: fifo_state encodings, frame sizes and reader FSM types.
// Used by the FIFO writer, the state controller and fifo_rd.
package fifo_pkg;

  localparam int unsigned POINT_NUM_DEF = 400;
  localparam int unsigned DATA_NUM_DEF  = POINT_NUM_DEF * 2;

  localparam int unsigned ST_W     = 3;
  localparam int unsigned DATA_W   = 10;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned LVL_W    = 11;

  localparam logic [ST_W-1:0] FS_IDLE       = 3'b111;
  localparam logic [ST_W-1:0] FS_WR_200X2   = 3'b011;
  localparam logic [ST_W-1:0] FS_WR_RD_LOOP = 3'b001;
  localparam logic [ST_W-1:0] FS_RD_400X2   = 3'b101;

  typedef enum logic [1:0] {R_IDLE, R_TRIM, R_READ, R_DONE} rd_state_e;
  typedef enum logic [1:0] {M_IDLE, M_TRIM, M_READ} rd_mode_e;

  // Pre-fill and unknown encodings both mean "leave the FIFO alone".
  function automatic rd_mode_e decode_mode(input logic [ST_W-1:0] st);
    case (st)
      FS_WR_RD_LOOP: return M_TRIM;
      FS_RD_400X2:   return M_READ;
      default:       return M_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_pat_chk.sv
// Test-pattern checker: each sample after the first of a frame must be previous+1 mod 256.
// Only instantiated when FIFO_RD_PATTERN_CHECK_EN is defined; the error flag is sticky until reset.
module fifo_pat_chk
  import fifo_pkg::*;
(
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                valid_i,
  input  logic                first_i,
  input  logic [SAMPLE_W-1:0] data_i,
  output logic                err_o
);

  logic [SAMPLE_W-1:0] prev_q;
  logic                err_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (valid_i) begin
      prev_q <= data_i;
      if (!first_i && (data_i != prev_q + SAMPLE_W'(1))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/fifo_rd.sv
// Capture-FIFO reader: idles during pre-fill, trims the FIFO in the write/read loop and delivers
// one frame of words on host request. Optional pattern checker: define FIFO_RD_PATTERN_CHECK_EN.
module fifo_rd
  import fifo_pkg::*;
#(
  parameter int unsigned POINT_NUM = POINT_NUM_DEF,
  parameter int unsigned DATA_NUM  = POINT_NUM * 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [ST_W-1:0]     fifo_state,
  input  logic                fifo_rd_flag,
  input  logic [DATA_W-1:0]   fifo_rd_data,
  input  logic [LVL_W-1:0]    fifo_rd_data_count,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic                frame_done,
  output logic                pattern_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_NUM);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DATA_NUM);
  localparam logic [LVL_W-1:0] TRIM_LVL = LVL_W'(DATA_NUM / 2);

  rd_state_e        state_q, state_d;
  rd_mode_e         mode;
  logic             rd_en_q, rd_en_d;
  logic             pend_q, pend_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [LVL_W-1:0] cnt_ahead;
  logic             unused_hi;

  assign mode      = decode_mode(fifo_state);
  assign cnt_ahead = LVL_W'(cnt_q) + LVL_W'(rd_en_q);
  assign unused_hi = ^fifo_rd_data[DATA_W-1:SAMPLE_W];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= R_IDLE;
      rd_en_q <= 1'b0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        pend_d = 1'b0;
        cnt_d  = '0;
        if (mode == M_TRIM)      state_d = R_TRIM;
        else if (mode == M_READ) state_d = R_READ;
      end
      R_TRIM: begin
        pend_d = 1'b0;
        cnt_d  = '0;
        if (mode == M_IDLE)      state_d = R_IDLE;
        else if (mode == M_READ) state_d = R_READ;
        else begin
          // Skip the cycle after a read so the occupancy count has caught up.
          rd_en_d = !rd_en_q && !fifo_empty && (fifo_rd_data_count >= TRIM_LVL);
        end
      end
      R_READ: begin
        if (mode != M_READ) begin
          // Abort: any read still in flight is discarded.
          state_d = (mode == M_TRIM) ? R_TRIM : R_IDLE;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          vld_d = rd_en_q;
          if (rd_en_q) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = R_DONE;
            done_d  = 1'b1;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            if (!fifo_empty && (cnt_ahead < LVL_LAST)) begin
              rd_en_d = 1'b1;
              pend_d  = 1'b0;
            end
          end else if (fifo_rd_flag) begin
            pend_d = 1'b1;
          end
        end
      end
      R_DONE: begin
        pend_d = 1'b0;
        if (mode != M_READ) begin
          state_d = (mode == M_TRIM) ? R_TRIM : R_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // The FIFO's read port is already registered, so the sample is muxed straight from it.
  assign fifo_rd_en   = rd_en_q;
  assign sample_valid = vld_q;
  assign sample_data  = vld_q ? fifo_rd_data[SAMPLE_W-1:0] : '0;
  assign rd_cnt       = cnt_q;
  assign frame_done   = done_q;

`ifdef FIFO_RD_PATTERN_CHECK_EN
  logic first_smp;
  assign first_smp = (cnt_q == CNT_W'(1));

  fifo_pat_chk u_pat_chk (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .valid_i   (vld_q),
    .first_i   (first_smp),
    .data_i    (sample_data),
    .err_o     (pattern_err)
  );
`else
  assign pattern_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd.sv
// Directed bench for fifo_rd with a behavioural FIFO read port and immediate-assertion checks.
module tb_fifo_rd;
  import fifo_pkg::*;

`ifdef FIFO_RD_PATTERN_CHECK_EN
  localparam logic PAT_EXP = 1'b1;
`else
  localparam logic PAT_EXP = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [2:0]       fifo_state = FS_IDLE;
  logic             fifo_rd_flag = 1'b0;
  logic [9:0]       fifo_rd_data = '0;
  logic [10:0]      fifo_rd_data_count;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [7:0]       sample_data;
  logic             sample_valid;
  logic [9:0]       rd_cnt;
  logic             frame_done;
  logic             pattern_err;

  logic             force_empty = 1'b0;
  logic [10:0]      lvl_q = '0;
  logic             empty_q = 1'b1;
  logic [9:0]       fq[$];

  int total = 0;
  int bad = 0;
  int n_rden = 0, n_done = 0, n_b2b = 0;
  logic rden_prev = 1'b0;
  logic [7:0] got[$];

  always #5 sys_clk = ~sys_clk;

  fifo_rd dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .fifo_state         (fifo_state),
    .fifo_rd_flag       (fifo_rd_flag),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_data_count (fifo_rd_data_count),
    .fifo_empty         (fifo_empty),
    .fifo_rd_en         (fifo_rd_en),
    .sample_data        (sample_data),
    .sample_valid       (sample_valid),
    .rd_cnt             (rd_cnt),
    .frame_done         (frame_done),
    .pattern_err        (pattern_err)
  );

  // Standard (non-FWFT) FIFO read port: data appears after the edge that samples rd_en.
  always @(posedge sys_clk) begin
    if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
    lvl_q   <= 11'(fq.size());
    empty_q <= (fq.size() == 0);
  end
  assign fifo_rd_data_count = lvl_q;
  assign fifo_empty = force_empty | empty_q;

  always @(negedge sys_clk) begin
    if (fifo_rd_en) n_rden++;
    if (fifo_rd_en && rden_prev) n_b2b++;
    rden_prev = fifo_rd_en;
    if (sample_valid) got.push_back(sample_data);
    if (frame_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // Park the reader, then refill the FIFO with n words counting up from first.
  task automatic load(input int n, input int first);
    fifo_state = FS_IDLE;
    cyc(2);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(10'((first + i) % 256));
    cyc(2);
  endtask

  task automatic do_read(output bit ok);
    ok = 1'b0;
    fifo_rd_flag = 1'b1;
    @(negedge sys_clk);
    fifo_rd_flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic read_n(input int n, output int timeouts);
    bit ok;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      do_read(ok);
      if (!ok) timeouts++;
    end
  endtask

  task automatic seq_errs(input int base, input int n, output int errs);
    errs = 0;
    if (got.size() < base + n) errs = n;
    else for (int i = 0; i < n; i++) if (got[base+i] !== 8'(i % 256)) errs++;
  endtask

  initial begin
    int r0, g0, d0, to, errs;
    bit ok;

    // Reset state
    cyc(2);
    chk("rst_rden", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_rdcnt", 32'(rd_cnt), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_paterr", 32'(pattern_err), 0);
    sys_rst_n = 1'b1;

    // Pre-fill and unknown encodings never read
    load(10, 0);
    r0 = n_rden;
    foreach (fq[i]) begin end
    fifo_state = FS_WR_200X2;
    for (int i = 0; i < 5; i++) begin fifo_rd_flag = 1'b1; cyc(1); fifo_rd_flag = 1'b0; cyc(3); end
    fifo_state = 3'b000;
    for (int i = 0; i < 5; i++) begin fifo_rd_flag = 1'b1; cyc(1); fifo_rd_flag = 1'b0; cyc(3); end
    chk("prefill_rden", 32'(n_rden - r0), 0);
    chk("prefill_level", 32'(fifo_rd_data_count), 10);
    chk("unknown_state_idle", 32'(dut.state_q), 32'(R_IDLE));

    // Trim in the write/read loop: 405 -> reads while level >= 400
    load(405, 0);
    r0 = n_rden; g0 = got.size();
    fifo_state = FS_WR_RD_LOOP;
    cyc(40);
    chk("trim_level", 32'(fifo_rd_data_count), 399);
    chk("trim_reads", 32'(n_rden - r0), 6);
    chk("trim_no_valid", 32'(got.size() - g0), 0);
    chk("trim_rdcnt", 32'(rd_cnt), 0);
    chk("trim_no_b2b", 32'(n_b2b), 0);

    // Full frame of 800 words, pattern 0..255 wrapping
    load(800, 0);
    g0 = got.size(); d0 = n_done;
    fifo_state = FS_RD_400X2;
    cyc(2);
    read_n(800, to);
    cyc(5);
    chk("frame_timeouts", 32'(to), 0);
    chk("frame_valid_cnt", 32'(got.size() - g0), 800);
    seq_errs(g0, 800, errs);
    chk("frame_seq_errs", 32'(errs), 0);
    chk("frame_rdcnt", 32'(rd_cnt), 800);
    chk("frame_done_once", 32'(n_done - d0), 1);
    chk("frame_paterr", 32'(pattern_err), 0);
    chk("frame_state_done", 32'(dut.state_q), 32'(R_DONE));

    // Flags after the frame are ignored until re-entry
    fq.push_back(10'd7);
    r0 = n_rden;
    for (int i = 0; i < 3; i++) begin fifo_rd_flag = 1'b1; cyc(1); fifo_rd_flag = 1'b0; cyc(3); end
    chk("done_no_reads", 32'(n_rden - r0), 0);

    // Request held while FIFO reports empty
    load(2, 42);
    fifo_state = FS_RD_400X2;
    cyc(2);
    chk("reentry_rdcnt", 32'(rd_cnt), 0);
    force_empty = 1'b1;
    r0 = n_rden;
    fifo_rd_flag = 1'b1; cyc(1); fifo_rd_flag = 1'b0;
    cyc(10);
    chk("empty_no_read", 32'(n_rden - r0), 0);
    chk("empty_rdcnt", 32'(rd_cnt), 0);
    force_empty = 1'b0;
    cyc(1);
    chk("empty_release_rden", 32'(fifo_rd_en), 1);
    cyc(1);
    chk("empty_release_valid", 32'(sample_valid), 1);
    chk("empty_release_data", 32'(sample_data), 42);
    chk("empty_release_rdcnt", 32'(rd_cnt), 1);

    // Abort at 300 with a read in flight, then a clean re-entry
    load(800, 0);
    g0 = got.size(); d0 = n_done;
    fifo_state = FS_RD_400X2;
    cyc(2);
    read_n(300, to);
    chk("abort_rdcnt300", 32'(rd_cnt), 300);
    fifo_rd_flag = 1'b1; cyc(1); fifo_rd_flag = 1'b0; cyc(1);
    chk("abort_inflight_rden", 32'(fifo_rd_en), 1);
    fifo_state = FS_IDLE;
    cyc(4);
    chk("abort_rdcnt", 32'(rd_cnt), 0);
    chk("abort_valid_cnt", 32'(got.size() - g0 + to), 300);
    chk("abort_no_done", 32'(n_done - d0), 0);
    load(800, 0);
    g0 = got.size(); d0 = n_done;
    fifo_state = FS_RD_400X2;
    cyc(2);
    read_n(800, to);
    cyc(5);
    chk("reframe_valid_cnt", 32'(got.size() - g0 + to), 800);
    seq_errs(g0, 800, errs);
    chk("reframe_seq_errs", 32'(errs), 0);
    chk("reframe_done_once", 32'(n_done - d0), 1);

    // Pattern 5,6,8
    load(0, 0);
    fq.push_back(10'd5); fq.push_back(10'd6); fq.push_back(10'd8);
    cyc(2);
    fifo_state = FS_RD_400X2;
    cyc(2);
    do_read(ok); do_read(ok); do_read(ok);
    chk("pat_on_8_valid", 32'(sample_data), 8);
    chk("pat_err_not_yet", 32'(pattern_err), 0);
    cyc(1);
    chk("pat_err_set", 32'(pattern_err), 32'(PAT_EXP));
    cyc(10);
    chk("pat_err_held", 32'(pattern_err), 32'(PAT_EXP));

    // Asynchronous reset mid-frame at rd_cnt=100
    load(800, 0);
    fifo_state = FS_RD_400X2;
    cyc(2);
    read_n(100, to);
    chk("rstmid_rdcnt100", 32'(rd_cnt), 100);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstmid_rden", 32'(fifo_rd_en), 0);
    chk("rstmid_valid", 32'(sample_valid), 0);
    chk("rstmid_data", 32'(sample_data), 0);
    chk("rstmid_rdcnt", 32'(rd_cnt), 0);
    chk("rstmid_done", 32'(frame_done), 0);
    chk("rstmid_paterr", 32'(pattern_err), 0);
    chk("rstmid_state", 32'(dut.state_q), 32'(R_IDLE));
    cyc(1);
    sys_rst_n = 1'b1;
    cyc(3);
    do_read(ok);
    chk("rstmid_resume_ok", 32'(ok), 1);
    chk("rstmid_resume_data", 32'(sample_data), 100);
    chk("rstmid_resume_rdcnt", 32'(rd_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
